// File: rtl/time_bin_collector.sv
// Sums every D samples into a bin and gathers L bins into a frame; out_valid rises the cycle after the D*L-th accept.
// While a frame is held (HOLD) in_ready is low and q_reg is frozen until out_ready completes the handshake.
module time_bin_collector #(
  parameter int N = 6,
  parameter int M = 3,
  parameter int D = 3,
  parameter int W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [W-1:0]                in_sample,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [W+$clog2(D)-1:0]      q_reg [N+M-2:0],
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [15:0]                 frame_cnt
);

  localparam int L   = N + M - 1;
  localparam int BW  = W + $clog2(D);
  localparam int SCW = (D > 1) ? $clog2(D) : 1;
  localparam int BCW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic [SCW-1:0]  sub_cnt_q, sub_cnt_d;
  logic [BCW-1:0]  bin_cnt_q, bin_cnt_d;
  logic [BW-1:0]   win_q [L-1:0];
  logic [BW-1:0]   win_d [L-1:0];
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [BW-1:0]   sum;

  // Handshake outputs come straight from the state flop; no input-to-output path.
  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign frame_cnt = frame_cnt_q;
  assign q_reg     = win_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sub_cnt_d   = sub_cnt_q;
    bin_cnt_d   = bin_cnt_q;
    win_d       = win_q;
    frame_cnt_d = frame_cnt_q;
    sum         = acc_q + BW'(in_sample);

    case (state_q)
      FILL: begin
        if (in_valid) begin
          if (sub_cnt_q == SCW'(D - 1)) begin
            for (int k = 0; k < L - 1; k++) begin
              win_d[k] = win_q[k+1];
            end
            win_d[L-1] = sum;
            acc_d      = '0;
            sub_cnt_d  = '0;
            if (bin_cnt_q == BCW'(L - 1)) begin
              bin_cnt_d = '0;
              state_d   = HOLD;
            end else begin
              bin_cnt_d = bin_cnt_q + 1'b1;
            end
          end else begin
            acc_d     = sum;
            sub_cnt_d = sub_cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = FILL;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      acc_q       <= '0;
      sub_cnt_q   <= '0;
      bin_cnt_q   <= '0;
      frame_cnt_q <= '0;
      for (int k = 0; k < L; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sub_cnt_q   <= sub_cnt_d;
      bin_cnt_q   <= bin_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      win_q       <= win_d;
    end
  end

endmodule

// File: tb/tb_time_bin_collector.sv
// Directed bench for time_bin_collector at default parameters (L=8, BW=10).
module tb_time_bin_collector;

  logic        clk;
  logic        rst;
  logic [7:0]  in_sample;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  q_reg [7:0];
  logic        out_valid;
  logic        out_ready;
  logic [15:0] frame_cnt;

  int tests;
  int fails;

  typedef struct {
    bit       rst;
    bit       in_valid;
    int       in_sample;
    bit       out_ready;
    bit       exp_in_ready;
    bit       exp_out_valid;
    int       exp_fc;
  } vec_t;

  vec_t vecs [25];
  int   exp_bins [8];

  time_bin_collector dut (
    .clk       (clk),
    .rst       (rst),
    .in_sample (in_sample),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q_reg     (q_reg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle, then sample just after the edge.
  task automatic cyc(input bit r, input bit v, input int s, input bit o);
    rst       = r;
    in_valid  = v;
    in_sample = s[7:0];
    out_ready = o;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string name, input bit ir, input bit ov, input int fc);
    chk({name, ".in_ready"},  int'(in_ready),  int'(ir));
    chk({name, ".out_valid"}, int'(out_valid), int'(ov));
    chk({name, ".frame_cnt"}, int'(frame_cnt), fc);
  endtask

  task automatic chk_bins_all(input string name, input int val);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s.q_reg[%0d]", name, k), int'(q_reg[k]), val);
    end
  endtask

  // Feeds 24 accepts of one value with out_ready low; out_valid must rise only after the last.
  task automatic fill(input string name, input int val, input bit gapped);
    for (int i = 0; i < 24; i++) begin
      cyc(1'b0, 1'b1, val, 1'b0);
      chk($sformatf("%s.out_valid@accept%0d", name, i + 1), int'(out_valid), int'(i == 23));
      if (gapped && i < 23) begin
        cyc(1'b0, 1'b0, val, 1'b0);
        chk($sformatf("%s.out_valid@gap%0d", name, i + 1), int'(out_valid), 0);
      end
    end
    chk({name, ".in_ready_hold"}, int'(in_ready), 0);
  endtask

  task automatic handshake(input string name, input int exp_fc);
    cyc(1'b0, 1'b0, 0, 1'b1);
    chk_flags(name, 1'b1, 1'b0, exp_fc);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; in_valid = 1'b0; in_sample = '0; out_ready = 1'b0;

    // Reset values
    cyc(1'b1, 1'b0, 0, 1'b0);
    cyc(1'b1, 1'b1, 5, 1'b1);
    chk_flags("reset", 1'b1, 1'b0, 0);
    chk_bins_all("reset", 0);

    // Default frame: samples 1..24 with out_ready held high
    for (int i = 0; i < 24; i++) begin
      vecs[i] = '{rst: 1'b0, in_valid: 1'b1, in_sample: i + 1, out_ready: 1'b1,
                  exp_in_ready: (i != 23), exp_out_valid: (i == 23), exp_fc: 0};
    end
    vecs[24] = '{rst: 1'b0, in_valid: 1'b1, in_sample: 99, out_ready: 1'b1,
                 exp_in_ready: 1'b1, exp_out_valid: 1'b0, exp_fc: 1};
    exp_bins = '{6, 15, 24, 33, 42, 51, 60, 69};

    for (int i = 0; i < 25; i++) begin
      cyc(vecs[i].rst, vecs[i].in_valid, vecs[i].in_sample, vecs[i].out_ready);
      chk_flags($sformatf("vec%0d", i), vecs[i].exp_in_ready, vecs[i].exp_out_valid, vecs[i].exp_fc);
    end
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("default.q_reg[%0d]", k), int'(q_reg[k]), exp_bins[k]);
    end

    // Backpressure: 5 stalled HOLD cycles with in_valid high, handshake on the 6th
    fill("bp_fill", 5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 7, 1'b0);
      chk_flags($sformatf("bp_hold%0d", i), 1'b0, 1'b1, 1);
      chk_bins_all($sformatf("bp_hold%0d", i), 15);
    end
    cyc(1'b0, 1'b1, 7, 1'b1);
    chk_flags("bp_handshake", 1'b1, 1'b0, 2);
    fill("bp_next", 4, 1'b0);
    chk_bins_all("bp_next", 12);
    handshake("bp_next_hs", 3);

    // Gapped input
    fill("gap", 2, 1'b1);
    chk_bins_all("gap", 6);
    handshake("gap_hs", 4);

    // Full scale: no wrap at 3*255
    fill("full", 255, 1'b0);
    chk_bins_all("full", 765);
    handshake("full_hs", 5);

    // Reset mid-fill discards partial bins and overrides a simultaneous accept
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 9, 1'b0);
    cyc(1'b1, 1'b1, 9, 1'b1);
    chk_flags("rst_mid", 1'b1, 1'b0, 0);
    chk_bins_all("rst_mid", 0);
    fill("post_rst", 1, 1'b0);
    chk_bins_all("post_rst", 3);
    handshake("post_rst_hs", 1);

    // Reset during HOLD beats a simultaneous handshake
    fill("hold_rst_fill", 3, 1'b0);
    cyc(1'b1, 1'b0, 0, 1'b1);
    chk_flags("rst_hold", 1'b1, 1'b0, 0);
    chk_bins_all("rst_hold", 0);

    // frame_cnt wraps 0xFFFF -> 0
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    fill("wrap_fill", 1, 1'b0);
    chk("wrap_pre", int'(frame_cnt), 65535);
    handshake("wrap_hs", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
